// File: rtl/wb_fifo_slave_pkg.sv
// rtl/wb_fifo_slave_pkg.sv - shared register map, status bit positions and bus states
package wb_fifo_slave_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_THRESH  = 2'd3;

    localparam int ST_COUNT_W = 9;
    localparam int ST_EMPTY   = 9;
    localparam int ST_FULL    = 10;
    localparam int ST_OVF     = 11;
    localparam int ST_UDF     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_t;

endpackage

// File: rtl/wb_fifo_slave_mem.sv
// rtl/wb_fifo_slave_mem.sv - synchronous byte FIFO with push/pop/flush and occupancy count
module wb_fifo_slave_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_tb,
    input  logic                     reset_tb,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               wdata,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (push && !full) begin
            wptr  <= wptr + 1'b1;
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            rptr  <= rptr + 1'b1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_tb) begin
        if (push && !full && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/wb_fifo_slave.sv
// rtl/wb_fifo_slave.sv - Wishbone classic responder fronting a byte FIFO; WB_FIFO_SLAVE_ERR_EN selects err termination
module wb_fifo_slave
    import wb_fifo_slave_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_tb,
    input  logic        reset_tb,
    input  logic [31:0] adr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    output logic        ack,
    output logic        err,
    output logic        rty,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_t  state;
    bus_state_t  state_nx;
    logic [3:0]  wcnt;
    logic [3:0]  wcnt_nx;
    logic [CW-1:0] count;
    logic [ST_COUNT_W-1:0] count9;
    logic        full;
    logic        empty;
    logic [7:0]  head;
    logic        irq_en;
    logic        ovf;
    logic        udf;
    logic [8:0]  thresh;
    logic        push;
    logic        pop;
    logic        flush;
    logic        err_case;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign rty         = 1'b0;
    assign count9      = ST_COUNT_W'(count);
    assign unused_bits = ^{adr[31:4], adr[1:0], sel[3:1], dat_i[31:9]};

    wb_fifo_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_tb   (clk_tb),
        .reset_tb (reset_tb),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wdata    (dat_i[7:0]),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: if (cyc && stb) begin
                if (WAIT_STATES == 0) begin
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                    wcnt_nx  = 4'(WAIT_STATES);
                end
            end
            WAIT: if (!cyc) begin
                state_nx = IDLE;
            end else begin
                wcnt_nx = wcnt - 4'd1;
                if (wcnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Side effects are decoded only in RESP so each transfer acts exactly once.
    always_comb begin
        push   = 1'b0;
        pop    = 1'b0;
        flush  = 1'b0;
        rd_val = '0;
        if (state == RESP) begin
            case (adr[3:2])
                REG_DATA: begin
                    if (we) push = sel[0];
                    else begin
                        pop    = 1'b1;
                        rd_val = empty ? 32'h0 : {24'h0, head};
                    end
                end
                REG_STATUS: if (!we) begin
                    rd_val[ST_COUNT_W-1:0] = count9;
                    rd_val[ST_EMPTY]       = empty;
                    rd_val[ST_FULL]        = full;
                    rd_val[ST_OVF]         = ovf;
                    rd_val[ST_UDF]         = udf;
                end
                REG_CONTROL: begin
                    if (we) flush = dat_i[1];
                    else    rd_val = {31'h0, irq_en};
                end
                REG_THRESH: if (!we) rd_val = {23'h0, thresh};
            endcase
        end
    end

`ifdef WB_FIFO_SLAVE_ERR_EN
    assign err_case = (push & full) | (pop & empty);
`else
    assign err_case = 1'b0;
`endif

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            ack    <= 1'b0;
            err    <= 1'b0;
            dat_o  <= '0;
            irq    <= 1'b0;
            irq_en <= 1'b0;
            thresh <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            ack   <= (state == RESP) && !err_case;
            err   <= err_case;
            dat_o <= rd_val;
            irq   <= irq_en && (count9 >= thresh) && (thresh != '0);
            if (flush) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (push && full)  ovf <= 1'b1;
                if (pop  && empty) udf <= 1'b1;
            end
            if (state == RESP && we) begin
                if (adr[3:2] == REG_CONTROL) irq_en <= dat_i[0];
                if (adr[3:2] == REG_THRESH)  thresh <= dat_i[8:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_fifo_slave.sv
// tb/tb_wb_fifo_slave.sv - self-checking bench for wb_fifo_slave (WAIT_STATES=1 and 4 instances)
module tb_wb_fifo_slave;
    import wb_fifo_slave_pkg::*;

`ifdef WB_FIFO_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_tb = 1'b0;
    logic        reset_tb = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, cyc4 = 1'b0, stb4 = 1'b0;
    logic [31:0] dat_o, dat_o4;
    logic        ack, err, rty, irq, ack4, err4, rty4, irq4;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  model_q[$];

    always #5 clk_tb = ~clk_tb;

    wb_fifo_slave #(.DEPTH(16), .WAIT_STATES(1)) u_dut (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .adr(adr), .dat_i(dat_i), .dat_o(dat_o),
        .sel(sel), .cyc(cyc), .stb(stb), .we(we), .ack(ack), .err(err), .rty(rty), .irq(irq)
    );

    wb_fifo_slave #(.DEPTH(16), .WAIT_STATES(4)) u_dut4 (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .adr(adr), .dat_i(dat_i), .dat_o(dat_o4),
        .sel(sel), .cyc(cyc4), .stb(stb4), .we(we), .ack(ack4), .err(err4), .rty(rty4), .irq(irq4)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  rg;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus(input bit w4, input logic wr, input logic [1:0] rg, input logic [31:0] wd,
                       output logic [31:0] rd, output logic gerr, output int lat);
        bit done = 1'b0;
        @(negedge clk_tb);
        adr = {28'h0, rg, 2'b00};
        dat_i = wd;
        sel = 4'h1;
        we = wr;
        if (w4) begin cyc4 = 1'b1; stb4 = 1'b1; end
        else    begin cyc  = 1'b1; stb  = 1'b1; end
        lat = -1;
        rd = '0;
        gerr = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk_tb);
            #1;
            if (w4 ? (ack4 | err4) : (ack | err)) begin
                done = 1'b1;
                lat  = i;
                rd   = w4 ? dat_o4 : dat_o;
                gerr = w4 ? err4 : err;
            end
        end
        @(negedge clk_tb);
        cyc = 1'b0; stb = 1'b0; cyc4 = 1'b0; stb4 = 1'b0; we = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_timeout: got no ack/err within 40 cycles, required one");
        end
    endtask

    task automatic do_xfer(input string nm, input bit w4, input logic wr, input logic [1:0] rg,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                           input int exp_lat);
        logic [31:0] rd;
        logic        ge;
        int          lat;
        logic [31:0] e;
        exp_q.push_back(exp_rd);
        bus(w4, wr, rg, wd, rd, ge, lat);
        e = exp_q.pop_front();
        chk({nm, "_data"}, rd, e);
        chk({nm, "_err"}, 32'(ge), 32'(exp_err));
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        bit seen;

        vt[0]  = '{"st_reset",  1'b0, REG_STATUS,  32'h0,  32'h200,  1'b0};
        vt[1]  = '{"wr_41",     1'b1, REG_DATA,    32'h41, 32'h0,    1'b0};
        vt[2]  = '{"wr_42",     1'b1, REG_DATA,    32'h42, 32'h0,    1'b0};
        vt[3]  = '{"wr_43",     1'b1, REG_DATA,    32'h43, 32'h0,    1'b0};
        vt[4]  = '{"st_cnt3",   1'b0, REG_STATUS,  32'h0,  32'h003,  1'b0};
        vt[5]  = '{"rd_41",     1'b0, REG_DATA,    32'h0,  32'h41,   1'b0};
        vt[6]  = '{"rd_42",     1'b0, REG_DATA,    32'h0,  32'h42,   1'b0};
        vt[7]  = '{"rd_43",     1'b0, REG_DATA,    32'h0,  32'h43,   1'b0};
        vt[8]  = '{"st_empty",  1'b0, REG_STATUS,  32'h0,  32'h200,  1'b0};
        vt[9]  = '{"rd_under",  1'b0, REG_DATA,    32'h0,  32'h0,    ERR_EN};
        vt[10] = '{"st_udf",    1'b0, REG_STATUS,  32'h0,  32'h1200, 1'b0};
        vt[11] = '{"flush",     1'b1, REG_CONTROL, 32'h2,  32'h0,    1'b0};
        vt[12] = '{"st_flush",  1'b0, REG_STATUS,  32'h0,  32'h200,  1'b0};
        vt[13] = '{"wr_thr",    1'b1, REG_THRESH,  32'h3,  32'h0,    1'b0};
        vt[14] = '{"rd_thr",    1'b0, REG_THRESH,  32'h0,  32'h3,    1'b0};
        vt[15] = '{"wr_ctl",    1'b1, REG_CONTROL, 32'h1,  32'h0,    1'b0};
        vt[16] = '{"rd_ctl",    1'b0, REG_CONTROL, 32'h0,  32'h1,    1'b0};

        repeat (3) @(negedge clk_tb);
        chk("rst_flags", 32'({ack, err, rty, irq, ack4, err4, rty4, irq4}), 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_dat4", dat_o4, 32'h0);
        reset_tb = 1'b1;

        for (int i = 0; i < 17; i++)
            do_xfer(vt[i].name, 1'b0, vt[i].wr, vt[i].rg, vt[i].wd, vt[i].exp, vt[i].exp_err, 3);

        // irq threshold crossing: THRESH=3, irq_en=1 already set by the table
        do_xfer("irq_p1", 1'b0, 1'b1, REG_DATA, 32'hA1, 32'h0, 1'b0, 3);
        do_xfer("irq_p2", 1'b0, 1'b1, REG_DATA, 32'hA2, 32'h0, 1'b0, 3);
        chk("irq_below", 32'(irq), 32'h0);
        do_xfer("irq_p3", 1'b0, 1'b1, REG_DATA, 32'hA3, 32'h0, 1'b0, 3);
        chk("irq_at_ack", 32'(irq), 32'h0);
        @(posedge clk_tb); #1;
        chk("irq_rise", 32'(irq), 32'h1);
        do_xfer("irq_pop", 1'b0, 1'b0, REG_DATA, 32'h0, 32'hA1, 1'b0, 3);
        chk("irq_hold", 32'(irq), 32'h1);
        @(posedge clk_tb); #1;
        chk("irq_fall", 32'(irq), 32'h0);
        chk("dat_idle", dat_o, 32'h0);
        do_xfer("flush2", 1'b0, 1'b1, REG_CONTROL, 32'h2, 32'h0, 1'b0, 3);
        do_xfer("st_flush2", 1'b0, 1'b0, REG_STATUS, 32'h0, 32'h200, 1'b0, 3);

        // overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) begin
            if (i < 16) model_q.push_back(8'(16 + i));
            do_xfer("push_full", 1'b0, 1'b1, REG_DATA, 32'(16 + i), 32'h0, (i == 16) && ERR_EN, 3);
        end
        do_xfer("st_full", 1'b0, 1'b0, REG_STATUS, 32'h0, 32'h0C10, 1'b0, 3);
        for (int i = 0; i < 16; i++) begin
            e = {24'h0, model_q.pop_front()};
            do_xfer("drain", 1'b0, 1'b0, REG_DATA, 32'h0, e, 1'b0, 3);
        end
        do_xfer("st_drained", 1'b0, 1'b0, REG_STATUS, 32'h0, 32'h0A00, 1'b0, 3);
        do_xfer("flush3", 1'b0, 1'b1, REG_CONTROL, 32'h2, 32'h0, 1'b0, 3);

        // cyc dropped during WAIT on the 4-wait-state instance
        @(negedge clk_tb);
        adr = {28'h0, REG_DATA, 2'b00}; dat_i = 32'h55; sel = 4'h1; we = 1'b1;
        cyc4 = 1'b1; stb4 = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(posedge clk_tb); #1; seen |= ack4 | err4; end
        @(negedge clk_tb);
        cyc4 = 1'b0; stb4 = 1'b0; we = 1'b0;
        repeat (8) begin @(posedge clk_tb); #1; seen |= ack4 | err4; end
        chk("abort_noack", 32'(seen), 32'h0);
        do_xfer("abort_st", 1'b1, 1'b0, REG_STATUS, 32'h0, 32'h200, 1'b0, 6);
        do_xfer("w4_push", 1'b1, 1'b1, REG_DATA, 32'h66, 32'h0, 1'b0, 6);
        do_xfer("w4_st", 1'b1, 1'b0, REG_STATUS, 32'h0, 32'h001, 1'b0, 6);

        // reset asserted while ack is high
        do_xfer("rst_thr", 1'b0, 1'b1, REG_THRESH, 32'h1, 32'h0, 1'b0, 3);
        do_xfer("rst_ctl", 1'b0, 1'b1, REG_CONTROL, 32'h1, 32'h0, 1'b0, 3);
        do_xfer("rst_push", 1'b0, 1'b1, REG_DATA, 32'h77, 32'h0, 1'b0, 3);
        @(posedge clk_tb); #1;
        chk("rst_irq_pre", 32'(irq), 32'h1);
        @(negedge clk_tb);
        adr = {28'h0, REG_DATA, 2'b00}; dat_i = 32'h78; sel = 4'h1; we = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk_tb);
        #1;
        chk("rst_ack_pre", 32'(ack), 32'h1);
        reset_tb = 1'b0;
        #1;
        chk("rst_ack_drop", 32'({ack, err, irq}), 32'h0);
        @(negedge clk_tb);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk_tb);
        reset_tb = 1'b1;
        do_xfer("rst_st", 1'b0, 1'b0, REG_STATUS, 32'h0, 32'h200, 1'b0, 3);
        do_xfer("rst_ctl0", 1'b0, 1'b0, REG_CONTROL, 32'h0, 32'h0, 1'b0, 3);
        do_xfer("rst_thr0", 1'b0, 1'b0, REG_THRESH, 32'h0, 32'h0, 1'b0, 3);
        do_xfer("rst_st4", 1'b1, 1'b0, REG_STATUS, 32'h0, 32'h200, 1'b0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
